// File: rtl/hourglass_stream_sorter.sv
// rtl/hourglass_stream_sorter.sv - streaming stable insertion sorter
// Keys are inserted into a sorted buffer as they arrive, then drained with arrival indices.
module hourglass_stream_sorter #(
  parameter int NUMBER_OF_ELEMENTS = 24,
  parameter int KEY_WIDTH          = 8,
  parameter int OUTPUT_INDEX_WIDTH = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          descending,
  input  logic [KEY_WIDTH-1:0]          axis_in_key,
  input  logic                          axis_in_valid,
  input  logic                          axis_in_last,
  output logic                          axis_in_ready,
  output logic [KEY_WIDTH-1:0]          axis_out_key,
  output logic [OUTPUT_INDEX_WIDTH-1:0] axis_out_index,
  output logic                          axis_out_valid,
  output logic                          axis_out_last,
  input  logic                          axis_out_ready,
  output logic                          busy
);
  localparam int CW = $clog2(NUMBER_OF_ELEMENTS + 1);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t                        state;
  logic [CW-1:0]                 count;
  logic [CW-1:0]                 rd_ptr;
  logic                          mode_desc;
  logic [KEY_WIDTH-1:0]          key_buf  [NUMBER_OF_ELEMENTS];
  logic [OUTPUT_INDEX_WIDTH-1:0] idx_buf  [NUMBER_OF_ELEMENTS];
  logic [KEY_WIDTH-1:0]          key_next [NUMBER_OF_ELEMENTS];
  logic [OUTPUT_INDEX_WIDTH-1:0] idx_next [NUMBER_OF_ELEMENTS];
  logic [NUMBER_OF_ELEMENTS-1:0] keep;
  logic [OUTPUT_INDEX_WIDTH-1:0] idx_in;
  logic                          in_fire;
  logic                          out_fire;
  logic                          ins_desc;

  assign axis_in_ready  = (state != DRAIN);
  assign axis_out_valid = (state == DRAIN);
  assign busy           = (state != IDLE);
  assign in_fire        = axis_in_valid && axis_in_ready;
  assign out_fire       = axis_out_valid && axis_out_ready;
  assign ins_desc       = (state == IDLE) ? descending : mode_desc;
  assign idx_in         = OUTPUT_INDEX_WIDTH'(count);
  assign axis_out_last  = axis_out_valid && (rd_ptr == count - CW'(1));
  assign axis_out_key   = axis_out_valid ? key_buf[rd_ptr] : '0;
  assign axis_out_index = axis_out_valid ? idx_buf[rd_ptr] : '0;

  // Entries that stay in place form a prefix; ties stay ahead of the new key for stability.
  always_comb begin
    keep = '0;
    for (int i = 0; i < NUMBER_OF_ELEMENTS; i++) begin
      keep[i] = (CW'(i) < count) &&
                (ins_desc ? (key_buf[i] >= axis_in_key) : (key_buf[i] <= axis_in_key));
    end
    key_next[0] = keep[0] ? key_buf[0] : axis_in_key;
    idx_next[0] = keep[0] ? idx_buf[0] : idx_in;
    for (int i = 1; i < NUMBER_OF_ELEMENTS; i++) begin
      if (keep[i]) begin
        key_next[i] = key_buf[i];
        idx_next[i] = idx_buf[i];
      end else if (keep[i-1]) begin
        key_next[i] = axis_in_key;
        idx_next[i] = idx_in;
      end else begin
        key_next[i] = key_buf[i-1];
        idx_next[i] = idx_buf[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      rd_ptr    <= '0;
      mode_desc <= 1'b0;
      for (int i = 0; i < NUMBER_OF_ELEMENTS; i++) begin
        key_buf[i] <= '0;
        idx_buf[i] <= '0;
      end
    end else begin
      if (in_fire) begin
        for (int i = 0; i < NUMBER_OF_ELEMENTS; i++) begin
          key_buf[i] <= key_next[i];
          idx_buf[i] <= idx_next[i];
        end
      end
      case (state)
        IDLE: begin
          if (in_fire) begin
            mode_desc <= descending;
            count     <= CW'(1);
            state     <= axis_in_last ? DRAIN : FILL;
          end
        end
        FILL: begin
          if (in_fire) begin
            count <= count + CW'(1);
            if (axis_in_last || (count + CW'(1) == CW'(NUMBER_OF_ELEMENTS)))
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_fire) begin
            if (axis_out_last) begin
              state  <= IDLE;
              count  <= '0;
              rd_ptr <= '0;
            end else begin
              rd_ptr <= rd_ptr + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hourglass_stream_sorter.sv
// tb/tb_hourglass_stream_sorter.sv - self-checking bench for hourglass_stream_sorter
module tb_hourglass_stream_sorter;
  typedef logic [7:0] key_t;
  typedef struct {
    logic [7:0] key;
    logic [4:0] idx;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       descending = 1'b0;
  logic [7:0] axis_in_key = '0;
  logic       axis_in_valid = 1'b0;
  logic       axis_in_last = 1'b0;
  logic       axis_in_ready;
  logic [7:0] axis_out_key;
  logic [4:0] axis_out_index;
  logic       axis_out_valid;
  logic       axis_out_last;
  logic       axis_out_ready = 1'b0;
  logic       busy;

  int    n_cmp = 0;
  int    n_err = 0;
  beat_t sb[$];

  always #5 clk = ~clk;

  hourglass_stream_sorter #(
    .NUMBER_OF_ELEMENTS(24), .KEY_WIDTH(8), .OUTPUT_INDEX_WIDTH(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .descending(descending),
    .axis_in_key(axis_in_key), .axis_in_valid(axis_in_valid),
    .axis_in_last(axis_in_last), .axis_in_ready(axis_in_ready),
    .axis_out_key(axis_out_key), .axis_out_index(axis_out_index),
    .axis_out_valid(axis_out_valid), .axis_out_last(axis_out_last),
    .axis_out_ready(axis_out_ready), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: repeated selection of the best remaining (key, arrival) pair.
  task automatic model_push(input key_t k[$], input bit desc);
    bit used[$];
    int n = k.size();
    for (int i = 0; i < n; i++) used.push_back(1'b0);
    for (int r = 0; r < n; r++) begin
      int best = -1;
      beat_t b;
      for (int j = 0; j < n; j++) begin
        if (!used[j]) begin
          if (best < 0) best = j;
          else if (desc ? (k[j] > k[best]) : (k[j] < k[best])) best = j;
        end
      end
      used[best] = 1'b1;
      b.key  = k[best];
      b.idx  = 5'(best);
      b.last = (r == n - 1);
      sb.push_back(b);
    end
  endtask

  task automatic send_batch(input key_t k[$], input bit desc, input bit use_last);
    int n = k.size();
    axis_out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      int t = 0;
      @(negedge clk);
      axis_in_key   = k[i];
      axis_in_valid = 1'b1;
      axis_in_last  = use_last && (i == n - 1);
      descending    = (i == 0) ? desc : ~desc;
      #1;
      while (!axis_in_ready && t < 100) begin
        @(negedge clk);
        t++;
        #1;
      end
      if (t >= 100) check("in_ready_timeout", 32'(t), 32'(0));
      @(posedge clk);
    end
    @(negedge clk);
    axis_in_valid = 1'b0;
    axis_in_last  = 1'b0;
    model_push(k, desc);
    #1;
    check("latency_out_valid", 32'(axis_out_valid), 32'(1));
    check("close_in_ready", 32'(axis_in_ready), 32'(0));
    check("close_busy", 32'(busy), 32'(1));
  endtask

  task automatic drain(input int n, input bit stall, input bit post);
    int   got = 0;
    int   cyc = 0;
    bit   held = 1'b0;
    key_t hk;
    logic [4:0] hi;
    logic hl;
    while (got < n && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      axis_out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (held) begin
        check("hold_valid", 32'(axis_out_valid), 32'(1));
        check("hold_key", 32'(axis_out_key), 32'(hk));
        check("hold_index", 32'(axis_out_index), 32'(hi));
        check("hold_last", 32'(axis_out_last), 32'(hl));
      end
      if (axis_out_valid && axis_out_ready) begin
        if (sb.size() == 0) begin
          check("scoreboard_empty", 32'(1), 32'(0));
        end else begin
          beat_t e = sb.pop_front();
          check("out_key", 32'(axis_out_key), 32'(e.key));
          check("out_index", 32'(axis_out_index), 32'(e.idx));
          check("out_last", 32'(axis_out_last), 32'(e.last));
        end
        got++;
        held = 1'b0;
      end else if (axis_out_valid) begin
        held = 1'b1;
        hk = axis_out_key;
        hi = axis_out_index;
        hl = axis_out_last;
      end else begin
        held = 1'b0;
      end
    end
    if (got < n) check("drain_timeout", 32'(got), 32'(n));
    if (post) begin
      @(negedge clk);
      #1;
      check("post_out_valid", 32'(axis_out_valid), 32'(0));
      check("post_in_ready", 32'(axis_in_ready), 32'(1));
      check("post_busy", 32'(busy), 32'(0));
      check("post_sb_empty", 32'(sb.size()), 32'(0));
    end
  endtask

  initial begin
    key_t k[$];

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(axis_in_ready), 32'(1));
    check("rst_out_valid", 32'(axis_out_valid), 32'(0));
    check("rst_out_last", 32'(axis_out_last), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_out_key", 32'(axis_out_key), 32'(0));
    check("rst_out_index", 32'(axis_out_index), 32'(0));

    // Full ascending batch of heavily duplicated keys, last on beat 24.
    k.delete();
    for (int i = 0; i < 24; i++) k.push_back(key_t'($urandom_range(0, 3)));
    send_batch(k, 1'b0, 1'b1);
    drain(24, 1'b0, 1'b1);

    // Descending 5,9,5,1.
    k = '{8'd5, 8'd9, 8'd5, 8'd1};
    send_batch(k, 1'b1, 1'b1);
    drain(4, 1'b0, 1'b1);

    // Single-element batch.
    k = '{8'h7F};
    send_batch(k, 1'b0, 1'b1);
    drain(1, 1'b0, 1'b1);

    // Auto-close after 24 beats without last.
    k.delete();
    for (int i = 0; i < 24; i++) k.push_back(key_t'($urandom_range(0, 255)));
    send_batch(k, 1'b1, 1'b0);
    drain(24, 1'b0, 1'b1);

    // Random backpressure on an 8-key batch.
    k.delete();
    for (int i = 0; i < 8; i++) k.push_back(key_t'($urandom_range(0, 15)));
    send_batch(k, 1'b0, 1'b1);
    drain(8, 1'b1, 1'b1);

    // Reset mid-drain after 3 of 10 outputs.
    k.delete();
    for (int i = 0; i < 10; i++) k.push_back(key_t'($urandom_range(0, 255)));
    send_batch(k, 1'b0, 1'b1);
    drain(3, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    axis_out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_out_valid", 32'(axis_out_valid), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_in_ready", 32'(axis_in_ready), 32'(1));
    sb.delete();

    k = '{8'd3, 8'd2};
    send_batch(k, 1'b0, 1'b1);
    drain(2, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
